// File: rtl/regfile_nr1w.sv
// Register file with NUM_RD registered read ports and one write port.
// After reset an INIT sequence clears every entry, one per cycle, before
// normal operation starts. Entry 0 always reads as zero.
// Optional macro REGFILE_BYPASS_EN: when defined, a same-edge read and write
// of the same nonzero address returns the new data (write-first). When not
// defined, the read returns the old entry value (read-first).
module regfile_nr1w #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0]            rs_read,
    input  logic [NUM_RD*DEPTH_LOG2-1:0] rs_addr,
    output logic [NUM_RD*WIDTH-1:0]      rs_rdata,
    input  logic                         rd_write,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    input  logic [WIDTH-1:0]             rd_wdata,
    output logic                         init_busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [DEPTH_LOG2-1:0]     clear_cnt_q, clear_cnt_d;
    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic                      mem_we;
    logic [DEPTH_LOG2-1:0]     mem_waddr;
    logic [WIDTH-1:0]          mem_wdata;
    logic [NUM_RD*WIDTH-1:0]   rdata_q, rdata_d;
    logic [DEPTH_LOG2-1:0]     raddr;

    // State and clear counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    // Next state and storage write port selection (clear in INIT, user write in RUN)
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = rd_addr;
        mem_wdata   = rd_wdata;
        case (state_q)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_cnt_q;
                mem_wdata   = '0;
                clear_cnt_d = clear_cnt_q + DEPTH_LOG2'(1);
                if (clear_cnt_q == DEPTH_LOG2'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = rd_write && (rd_addr != '0);
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Storage array: no reset term, writes blocked while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Per-port read data selection; disabled ports hold their last value
    always_comb begin
        rdata_d = rdata_q;
        raddr   = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            raddr = rs_addr[i*DEPTH_LOG2 +: DEPTH_LOG2];
            if (rs_read[i]) begin
                if ((state_q == ST_INIT) || (raddr == '0)) begin
                    rdata_d[i*WIDTH +: WIDTH] = '0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    if (rd_write && (rd_addr == raddr)) begin
                        rdata_d[i*WIDTH +: WIDTH] = rd_wdata;
                    end else begin
                        rdata_d[i*WIDTH +: WIDTH] = mem_q[raddr];
                    end
`else
                    rdata_d[i*WIDTH +: WIDTH] = mem_q[raddr];
`endif
                end
            end
        end
    end

    // Read data output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rs_rdata  = rdata_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: doc/regfile_nr1w.md
REGFILE_NR1W -- requirements
Module: regfile_nr1w

Interface
REQ-001 Parameter WIDTH, default 32, shall set the data width of every entry.
REQ-002 Parameter DEPTH_LOG2, default 4, shall set the entry count: DEPTH = 2**DEPTH_LOG2.
REQ-003 Parameter NUM_RD, default 2, range 1..4, shall set the number of read ports.
REQ-004 Port clk, input, 1 bit: the single clock; all state shall change on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port rs_read, input, NUM_RD bits: per-port read enable; bit i belongs to port i.
REQ-007 Port rs_addr, input, NUM_RD*DEPTH_LOG2 bits: read addresses; port i occupies slice [i*DEPTH_LOG2 +: DEPTH_LOG2].
REQ-008 Port rs_rdata, output, NUM_RD*WIDTH bits: registered read data; port i occupies slice [i*WIDTH +: WIDTH].
REQ-009 Port rd_write, input, 1 bit: write enable.
REQ-010 Port rd_addr, input, DEPTH_LOG2 bits: write address.
REQ-011 Port rd_wdata, input, WIDTH bits: write data.
REQ-012 Port init_busy, output, 1 bit: high while the post-reset clear sequence runs.

Function
REQ-013 Storage shall be DEPTH x WIDTH flops with no reset term; contents shall be cleared only by the INIT sequence.
REQ-014 FSM states shall be INIT and RUN; INIT -> RUN shall occur on the edge where the clear counter equals DEPTH-1.
REQ-015 In INIT, each edge shall write zero to entry clear_cnt and increment clear_cnt, so INIT lasts exactly DEPTH cycles after rst_n deasserts.
REQ-016 init_busy shall be 1 in INIT and 0 in RUN.
REQ-017 In INIT, rd_write shall be ignored; a port with rs_read high shall load zero into its rs_rdata.
REQ-018 In RUN, rd_write=1 with rd_addr!=0 shall write rd_wdata to entry rd_addr at the edge; writes to address 0 shall be discarded.
REQ-019 Entry 0 shall always read as zero.
REQ-020 In RUN, rs_read[i]=1 at an edge shall load entry rs_addr[i] into rs_rdata[i] at that edge: one-cycle latency.
REQ-021 rs_read[i]=0 shall hold rs_rdata[i] unchanged.
REQ-022 Read ports shall operate independently; identical addresses on several ports shall return identical data.
REQ-023 Same-edge read and write to the same nonzero address shall follow REQ-033/REQ-034.

Reset
REQ-024 rst_n low shall immediately force all rs_rdata to 0, init_busy to 1, clear_cnt to 0 and the state to INIT, regardless of clk.
REQ-025 Reset asserted mid-INIT or mid-RUN shall abort the current operation; the full DEPTH-cycle INIT shall restart after release.
REQ-026 No write shall reach storage while rst_n is low.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN shall select write-to-read forwarding.
REQ-028 With the macro defined, a same-edge read and write of the same nonzero address in RUN shall load rd_wdata into rs_rdata: write-first.
REQ-029 Without the macro, the same case shall load the pre-write entry value: read-first.

Verification
REQ-030 Reset, DEPTH=16: release rst_n -> init_busy=1 for exactly 16 cycles; then every address read on every port = 0.
REQ-031 RUN: write 0xDEADBEEF to addr 5; next cycle read addr 5 on ports 0 and 1 -> both rs_rdata = 0xDEADBEEF one cycle later.
REQ-032 Write 0x12345678 to addr 0, then read addr 0 -> 0x00000000.
REQ-033 Addr 7 holds 0x1; same edge: write 0x2 to addr 7 and read addr 7 -> 0x2 with REGFILE_BYPASS_EN defined.
REQ-034 Same stimulus as REQ-033 without the macro -> 0x1 on that read, 0x2 on the following read.
REQ-035 Reset pulse during RUN with addr 3 = 0xA5 -> rs_rdata = 0 at once, INIT repeats for 16 cycles, addr 3 reads 0; rd_write pulsed during INIT leaves no entry changed.
